// File: rtl/cmd_seq_defs.sv
// Shared definitions for the command sequencer: state encoding, a constant
// clog2 helper and the default response timeout.
// Optional feature macro: CMD_SEQ_STEP_EN adds the PAUSE state for single-step.
package cmd_seq_defs;

  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RSP   = 3'd2,
    ST_ACK   = 3'd3
`ifdef CMD_SEQ_STEP_EN
    , ST_PAUSE = 3'd4
`endif
  } state_e;

  // Ceiling log2 usable in parameter and port width expressions.
  function automatic int cs_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/cmd_seq_mem.sv
// Program store for the command sequencer: DEPTH x DATA_W register array,
// one synchronous write port and one asynchronous read port.
module cmd_seq_mem
  import cmd_seq_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [cs_clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [cs_clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous write of one program slot.
  // NOTE: the array has no reset; contents are defined only by loads, which keeps it a plain register file / RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cmd_sequencer.sv
// Request/response command sequencer: issues a programmed list of command
// words over the req/rsp handshake, captures each response, with timeout
// and abort. Optional feature macro: CMD_SEQ_STEP_EN (step_mode/step ports
// and the PAUSE state for single-stepping between words).
module cmd_sequencer
  import cmd_seq_defs::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic [cs_clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]          load_data,
  input  logic [cs_clog2(DEPTH):0]   prog_len,
  input  logic                       start,
  input  logic                       abort,
  output logic                       req_vaild,
  input  logic                       req_ready,
  output logic [DATA_W-1:0]          r_in,
  input  logic                       rsp_vaild,
  output logic                       rsp_ready,
  input  logic [DATA_W-1:0]          rsp_data,
  output logic [DATA_W-1:0]          last_rsp,
  output logic [cs_clog2(DEPTH)-1:0] cur_idx,
  output logic                       busy,
  output logic                       done,
`ifdef CMD_SEQ_STEP_EN
  input  logic                       step_mode,
  input  logic                       step,
`endif
  output logic                       err_timeout
);

  localparam int AW = cs_clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? cs_clog2(TIMEOUT_CYC) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [LW-1:0]     len, len_nxt;
  logic              req_vaild_nxt, rsp_ready_nxt, done_nxt, err_nxt;
  logic [DATA_W-1:0] r_in_nxt, last_rsp_nxt, rd_data;
  logic [AW-1:0]     cur_idx_nxt, nxt_idx, rd_addr;
  logic [LW-1:0]     start_len;
  logic              is_last, timeout_hit;

  assign busy        = (state != ST_IDLE);
  assign nxt_idx     = cur_idx + AW'(1);
  assign rd_addr     = (state == ST_IDLE) ? '0 : nxt_idx;
  assign start_len   = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  assign is_last     = ({1'b0, cur_idx} == (len - LW'(1)));
  assign timeout_hit = TIMEOUT_EN && (timer == TIMER_LAST);

  // Loads are locked out while a program runs so the words in flight stay stable.
  cmd_seq_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (load_en & ~busy),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state and next-register values; abort overrides every state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_nxt     = state;
    timer_nxt     = timer;
    len_nxt       = len;
    req_vaild_nxt = req_vaild;
    rsp_ready_nxt = rsp_ready;
    r_in_nxt      = r_in;
    last_rsp_nxt  = last_rsp;
    cur_idx_nxt   = cur_idx;
    err_nxt       = err_timeout;
    done_nxt      = 1'b0;
    if (abort) begin
      state_nxt     = ST_IDLE;
      req_vaild_nxt = 1'b0;
      rsp_ready_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_nxt = 1'b0;
            if (start_len == '0) begin
              done_nxt = 1'b1;
            end else begin
              len_nxt       = start_len;
              cur_idx_nxt   = '0;
              r_in_nxt      = rd_data;
              req_vaild_nxt = 1'b1;
              state_nxt     = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (req_ready) begin
            req_vaild_nxt = 1'b0;
            timer_nxt     = '0;
            state_nxt     = ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_vaild) begin
            last_rsp_nxt  = rsp_data;
            rsp_ready_nxt = 1'b1;
            state_nxt     = ST_ACK;
          end else if (timeout_hit) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        ST_ACK: begin
          rsp_ready_nxt = 1'b0;
          if (is_last) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
`ifdef CMD_SEQ_STEP_EN
          else if (step_mode) begin
            state_nxt = ST_PAUSE;
          end
`endif
          else begin
            cur_idx_nxt   = nxt_idx;
            r_in_nxt      = rd_data;
            req_vaild_nxt = 1'b1;
            state_nxt     = ST_REQ;
          end
        end
`ifdef CMD_SEQ_STEP_EN
        ST_PAUSE: begin
          if (step) begin
            cur_idx_nxt   = nxt_idx;
            r_in_nxt      = rd_data;
            req_vaild_nxt = 1'b1;
            state_nxt     = ST_REQ;
          end
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      len         <= '0;
      req_vaild   <= 1'b0;
      rsp_ready   <= 1'b0;
      r_in        <= '0;
      last_rsp    <= '0;
      cur_idx     <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      len         <= len_nxt;
      req_vaild   <= req_vaild_nxt;
      rsp_ready   <= rsp_ready_nxt;
      r_in        <= r_in_nxt;
      last_rsp    <= last_rsp_nxt;
      cur_idx     <= cur_idx_nxt;
      done        <= done_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule
